// File: rtl/bulls_cows_pkg.sv
// Shared types for the Bulls & Cows game core: FSM state encoding and winner codes.
package bulls_cows_pkg;

  typedef enum logic [2:0] {
    READ_S1 = 3'd0,
    READ_S2 = 3'd1,
    GUESS   = 3'd2,
    SCORE   = 3'd3,
    SHOW    = 3'd4,
    WIN     = 3'd5
  } bc_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

endpackage

// File: rtl/bc_entry_check.sv
// Combinational entry validator: every digit below BASE and all digits pairwise distinct.
module bc_entry_check #(
  parameter int NDIGITS = 4,
  parameter int DIGIT_W = 4,
  parameter int BASE    = 10
) (
  input  logic [NDIGITS*DIGIT_W-1:0] sw,
  output logic                       valid
);

  // One extra bit so BASE == 2**DIGIT_W is representable.
  localparam logic [DIGIT_W:0] BASE_L = BASE[DIGIT_W:0];

  logic [NDIGITS-1:0]         in_range;
  logic [NDIGITS*NDIGITS-1:0] clash;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_digit
      assign in_range[gi] = ({1'b0, sw[gi*DIGIT_W +: DIGIT_W]} < BASE_L);
      for (gj = 0; gj < NDIGITS; gj++) begin : g_pair
        if (gj > gi) begin : g_cmp
          assign clash[gi*NDIGITS+gj] = (sw[gi*DIGIT_W +: DIGIT_W] == sw[gj*DIGIT_W +: DIGIT_W]);
        end else begin : g_none
          assign clash[gi*NDIGITS+gj] = 1'b0;
        end
      end
    end
  endgenerate

  assign valid = (&in_range) & ~(|clash);

endmodule

// File: rtl/bulls_cows_engine.sv
// Two-player Bulls & Cows core: secret entry, alternating guesses, serial scoring, win detect.
// Optional macro BC_TURN_LIMIT_EN ends the game as a draw after MAX_TURNS rounds.
module bulls_cows_engine
  import bulls_cows_pkg::*;
#(
  parameter  int NDIGITS   = 4,
  parameter  int DIGIT_W   = 4,
  parameter  int BASE      = 10,
  parameter  int MAX_TURNS = 15,
  localparam int CNT_W     = $clog2(NDIGITS + 1),
  localparam int TURN_W    = $clog2(MAX_TURNS + 1)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       confirma,
  input  logic [NDIGITS*DIGIT_W-1:0] sw,
  output logic [2:0]                 state_o,
  output logic                       player_o,
  output logic                       entry_err,
  output logic                       result_valid,
  output logic [CNT_W-1:0]           bulls_o,
  output logic [CNT_W-1:0]           cows_o,
  output logic [TURN_W-1:0]          turn_o,
  output logic [1:0]                 winner_o
);

  localparam int SW_W  = NDIGITS * DIGIT_W;
  localparam int IDX_W = $clog2(NDIGITS);

  bc_state_t          state_q, state_d;
  logic               player_q, player_d;
  logic               err_q, err_d;
  logic               rv_q, rv_d;
  logic [CNT_W-1:0]   bulls_q, bulls_d;
  logic [CNT_W-1:0]   cows_q, cows_d;
  logic [TURN_W-1:0]  turn_q, turn_d;
  logic [1:0]         winner_q, winner_d;
  logic [SW_W-1:0]    sec1_q, sec1_d;
  logic [SW_W-1:0]    sec2_q, sec2_d;
  logic [SW_W-1:0]    guess_q, guess_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               entry_ok;
  logic [DIGIT_W-1:0] cur_digit;
  logic [DIGIT_W-1:0] guess_dig  [NDIGITS];
  logic [DIGIT_W-1:0] target_dig [NDIGITS];
  logic [NDIGITS-1:0] hit;
  logic               is_bull;
  logic               is_cow;
  logic [TURN_W-1:0]  turn_sat;

  bc_entry_check #(
    .NDIGITS (NDIGITS),
    .DIGIT_W (DIGIT_W),
    .BASE    (BASE)
  ) u_entry_check (
    .sw    (sw),
    .valid (entry_ok)
  );

  // The acting player is always scored against the other player's secret.
  genvar gi;
  generate
    for (gi = 0; gi < NDIGITS; gi++) begin : g_score
      assign guess_dig[gi]  = guess_q[gi*DIGIT_W +: DIGIT_W];
      assign target_dig[gi] = player_q ? sec1_q[gi*DIGIT_W +: DIGIT_W]
                                       : sec2_q[gi*DIGIT_W +: DIGIT_W];
      assign hit[gi]        = (target_dig[gi] == cur_digit);
    end
  endgenerate

  assign cur_digit = guess_dig[idx_q];
  assign is_bull   = hit[idx_q];
  assign is_cow    = (|hit) & ~is_bull;
  assign turn_sat  = (&turn_q) ? turn_q : turn_q + 1'b1;

`ifdef BC_TURN_LIMIT_EN
  localparam logic [TURN_W-1:0] TURN_LIMIT = TURN_W'(MAX_TURNS);
`endif

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    err_d    = 1'b0;
    rv_d     = rv_q;
    bulls_d  = bulls_q;
    cows_d   = cows_q;
    turn_d   = turn_q;
    winner_d = winner_q;
    sec1_d   = sec1_q;
    sec2_d   = sec2_q;
    guess_d  = guess_q;
    idx_d    = idx_q;
    case (state_q)
      READ_S1: if (confirma) begin
        if (entry_ok) begin
          sec1_d  = sw;
          state_d = READ_S2;
        end else begin
          err_d = 1'b1;
        end
      end
      READ_S2: if (confirma) begin
        if (entry_ok) begin
          sec2_d   = sw;
          player_d = 1'b0;
          state_d  = GUESS;
        end else begin
          err_d = 1'b1;
        end
      end
      GUESS: if (confirma) begin
        if (entry_ok) begin
          guess_d = sw;
          bulls_d = '0;
          cows_d  = '0;
          rv_d    = 1'b0;
          idx_d   = '0;
          state_d = SCORE;
        end else begin
          err_d = 1'b1;
        end
      end
      SCORE: begin
        if (is_bull) begin
          bulls_d = bulls_q + 1'b1;
        end else if (is_cow) begin
          cows_d = cows_q + 1'b1;
        end
        if (idx_q == IDX_W'(NDIGITS - 1)) begin
          rv_d    = 1'b1;
          state_d = SHOW;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SHOW: begin
        if (bulls_q == CNT_W'(NDIGITS)) begin
          state_d  = WIN;
          winner_d = player_q ? WIN_P2 : WIN_P1;
        end else if (confirma) begin
          state_d  = GUESS;
          player_d = ~player_q;
          if (player_q) begin
            turn_d = turn_sat;
`ifdef BC_TURN_LIMIT_EN
            if (turn_sat == TURN_LIMIT) begin
              state_d  = WIN;
              winner_d = WIN_DRAW;
              player_d = player_q;
            end
`endif
          end
        end
      end
      WIN: begin
      end
      default: state_d = READ_S1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= READ_S1;
      player_q <= 1'b0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
      bulls_q  <= '0;
      cows_q   <= '0;
      turn_q   <= '0;
      winner_q <= WIN_NONE;
      sec1_q   <= '0;
      sec2_q   <= '0;
      guess_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      player_q <= player_d;
      err_q    <= err_d;
      rv_q     <= rv_d;
      bulls_q  <= bulls_d;
      cows_q   <= cows_d;
      turn_q   <= turn_d;
      winner_q <= winner_d;
      sec1_q   <= sec1_d;
      sec2_q   <= sec2_d;
      guess_q  <= guess_d;
      idx_q    <= idx_d;
    end
  end

  assign state_o      = state_q;
  assign player_o     = player_q;
  assign entry_err    = err_q;
  assign result_valid = rv_q;
  assign bulls_o      = bulls_q;
  assign cows_o       = cows_q;
  assign turn_o       = turn_q;
  assign winner_o     = winner_q;

endmodule

// File: tb/tb_bulls_cows_engine.sv
// Bench for bulls_cows_engine: directed game scenarios plus random play against a game-level model.
module tb_bulls_cows_engine;
  import bulls_cows_pkg::*;

  localparam int N    = 4;
  localparam int DW   = 4;
  localparam int BASE = 10;
`ifdef BC_TURN_LIMIT_EN
  localparam int MT = 2;
`else
  localparam int MT = 3;
`endif
  localparam int TW = $clog2(MT + 1);
  localparam int CW = $clog2(N + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              conf;
  logic [N*DW-1:0]   sw;
  logic [2:0]        state_o;
  logic              player_o;
  logic              entry_err;
  logic              result_valid;
  logic [CW-1:0]     bulls_o;
  logic [CW-1:0]     cows_o;
  logic [TW-1:0]     turn_o;
  logic [1:0]        winner_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  bulls_cows_engine #(
    .NDIGITS   (N),
    .DIGIT_W   (DW),
    .BASE      (BASE),
    .MAX_TURNS (MT)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .confirma     (conf),
    .sw           (sw),
    .state_o      (state_o),
    .player_o     (player_o),
    .entry_err    (entry_err),
    .result_valid (result_valid),
    .bulls_o      (bulls_o),
    .cows_o       (cows_o),
    .turn_o       (turn_o),
    .winner_o     (winner_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dig(input logic [N*DW-1:0] v, input int i);
    return int'(v[i*DW +: DW]);
  endfunction

  function automatic bit entry_ok(input logic [N*DW-1:0] v);
    for (int i = 0; i < N; i++) begin
      if (dig(v, i) >= BASE) return 1'b0;
      for (int j = i + 1; j < N; j++)
        if (dig(v, i) == dig(v, j)) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Game-level model: state name, whose turn, score of the last full guess.
  bc_state_t m_state = READ_S1;
  int m_player = 0, m_err = 0, m_rv = 0, m_bulls = 0, m_cows = 0;
  int m_turn = 0, m_winner = 0, m_wait = 0, m_pb = 0, m_pc = 0;
  int m_sec[2][N];

  always @(posedge clk) begin
    if (rst) begin
      m_state = READ_S1; m_player = 0; m_err = 0; m_rv = 0;
      m_bulls = 0; m_cows = 0; m_turn = 0; m_winner = 0;
      for (int i = 0; i < N; i++) begin m_sec[0][i] = 0; m_sec[1][i] = 0; end
    end else begin
      m_err = 0;
      case (m_state)
        READ_S1, READ_S2, GUESS: if (conf) begin
          if (!entry_ok(sw)) begin
            m_err = 1;
          end else if (m_state == READ_S1) begin
            for (int i = 0; i < N; i++) m_sec[0][i] = dig(sw, i);
            m_state = READ_S2;
          end else if (m_state == READ_S2) begin
            for (int i = 0; i < N; i++) m_sec[1][i] = dig(sw, i);
            m_player = 0;
            m_state = GUESS;
          end else begin
            m_pb = 0; m_pc = 0;
            for (int i = 0; i < N; i++) begin
              if (dig(sw, i) == m_sec[1-m_player][i]) m_pb++;
              else for (int j = 0; j < N; j++)
                if (dig(sw, i) == m_sec[1-m_player][j]) m_pc++;
            end
            m_rv = 0; m_wait = N; m_state = SCORE;
          end
        end
        SCORE: begin
          m_wait--;
          if (m_wait == 0) begin
            m_state = SHOW; m_rv = 1; m_bulls = m_pb; m_cows = m_pc;
          end
        end
        SHOW: begin
          if (m_bulls == N) begin
            m_state = WIN; m_winner = m_player + 1;
          end else if (conf) begin
            if (m_player == 1 && m_turn < (1 << TW) - 1) m_turn++;
`ifdef BC_TURN_LIMIT_EN
            if (m_player == 1 && m_turn == MT) begin
              m_state = WIN; m_winner = 3;
            end else begin
              m_state = GUESS; m_player = 1 - m_player;
            end
`else
            m_state = GUESS; m_player = 1 - m_player;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", int'(state_o), int'(m_state));
      chk("player", int'(player_o), m_player);
      chk("entry_err", int'(entry_err), m_err);
      chk("result_valid", int'(result_valid), m_rv);
      chk("turn", int'(turn_o), m_turn);
      chk("winner", int'(winner_o), m_winner);
      if (m_rv != 0) begin
        chk("bulls", int'(bulls_o), m_bulls);
        chk("cows", int'(cows_o), m_cows);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [N*DW-1:0] v);
    sw = v; conf = 1'b1;
    tick();
    conf = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic miss_round(input logic [N*DW-1:0] g1, input logic [N*DW-1:0] g2);
    press(g1); repeat (N) tick(); press(16'h0000);
    press(g2); repeat (N) tick(); press(16'h0000);
  endtask

  function automatic logic [N*DW-1:0] rand_valid();
    int pool[BASE];
    logic [N*DW-1:0] v;
    for (int i = 0; i < BASE; i++) pool[i] = i;
    for (int i = 0; i < N; i++) begin
      int k, t;
      k = $urandom_range(BASE - 1, i);
      t = pool[i]; pool[i] = pool[k]; pool[k] = t;
      v[i*DW +: DW] = DW'(pool[i]);
    end
    return v;
  endfunction

  function automatic logic [N*DW-1:0] opp_secret();
    logic [N*DW-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(m_sec[1-m_player][i]);
    return v;
  endfunction

  initial begin
    rst = 1'b1; conf = 1'b0; sw = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset state", int'(state_o), 0);
    chk("reset outputs", int'({player_o, entry_err, result_valid, bulls_o, cows_o, turn_o, winner_o}), 0);

    // Rejected entries leave READ_S1 untouched
    press(16'h1123);
    chk("rej dup err", int'(entry_err), 1);
    chk("rej dup state", int'(state_o), 0);
    tick();
    chk("rej err pulse", int'(entry_err), 0);
    press(16'h12A4);
    chk("rej range err", int'(entry_err), 1);
    chk("rej range state", int'(state_o), 0);

    press(16'h1234);
    chk("setup s2", int'(state_o), 1);
    press(16'h5678);
    chk("setup guess", int'(state_o), 2);
    chk("setup player", int'(player_o), 0);
    chk("setup err", int'(entry_err), 0);

    // P1 guesses 5687 against 5678: two bulls, two cows, valid at t+5
    press(16'h5687);
    repeat (3) tick();
    chk("latency rv early", int'(result_valid), 0);
    tick();
    chk("latency rv", int'(result_valid), 1);
    chk("score bulls", int'(bulls_o), 2);
    chk("score cows", int'(cows_o), 2);

    // Reset in the middle of scoring
    press(16'h0000);
    press(16'h9012);
    tick();
    do_reset();
    chk("abort state", int'(state_o), 0);
    chk("abort outputs", int'({player_o, entry_err, result_valid, bulls_o, cows_o, turn_o, winner_o}), 0);

    // P1 misses, P2 finds P1's secret
    press(16'h1234); press(16'h5678);
    press(16'h9012); repeat (N) tick();
    chk("miss bulls", int'(bulls_o), 0);
    press(16'h0000);
    chk("p2 turn", int'(player_o), 1);
    chk("p2 turn count", int'(turn_o), 0);
    press(16'h1234); repeat (N) tick();
    chk("win bulls", int'(bulls_o), 4);
    tick();
    chk("win state", int'(state_o), 5);
    chk("win winner", int'(winner_o), 2);
    chk("win turn", int'(turn_o), 0);
    press(16'h5678);
    chk("win frozen", int'(state_o), 5);

    // Round counting: saturation, or the draw limit when enabled
    do_reset();
    press(16'h1234); press(16'h5678);
`ifdef BC_TURN_LIMIT_EN
    miss_round(16'h9012, 16'h9870);
    chk("limit turn1", int'(turn_o), 1);
    miss_round(16'h9012, 16'h9870);
    chk("limit state", int'(state_o), 5);
    chk("limit winner", int'(winner_o), 3);
    chk("limit turn", int'(turn_o), 2);
`else
    for (int r = 0; r < 5; r++) miss_round(16'h9012, 16'h9870);
    chk("sat turn", int'(turn_o), 3);
    chk("sat winner", int'(winner_o), 0);
    chk("sat state", int'(state_o), 2);
`endif

    // Random play
    for (int g = 0; g < 8; g++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        int r;
        r = $urandom_range(9, 0);
        if (r < 3)      sw = 16'($urandom);
        else if (r < 8) sw = rand_valid();
        else            sw = opp_secret();
        conf = ($urandom_range(2, 0) == 0);
        rst  = ($urandom_range(299, 0) == 0);
        tick();
      end
      conf = 1'b0; rst = 1'b0;
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
